// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants and result entry type for the write-back queue
package wb_pkg;
   localparam int REG_ZERO      = 0;
   localparam int DEFAULT_DEPTH = 4;
   localparam int DATA_W        = 32;
   localparam int ADDR_W        = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] reg_idx;
      logic [DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// rtl/wb_queue_if.sv - result offer handshake between execute/memory stages and the write-back queue
interface wb_queue_if #(
   parameter int ADDR_W = wb_pkg::ADDR_W,
   parameter int DATA_W = wb_pkg::DATA_W
);
   logic              result_valid;
   logic              result_ready;
   logic [ADDR_W-1:0] result_reg;
   logic [DATA_W-1:0] result_data;

   modport master (
      output result_valid, result_reg, result_data,
      input  result_ready
   );

   modport slave (
      input  result_valid, result_reg, result_data,
      output result_ready
   );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular result storage with registered full/empty; WB_FORWARD_EN exposes contents
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     full_o,
   output logic                     empty_o
`ifdef WB_FORWARD_EN
   ,
   output logic [WIDTH-1:0]         mem_o [DEPTH],
   output logic [$clog2(DEPTH)-1:0] rd_ptr_o,
   output logic [$clog2(DEPTH):0]   count_o
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, empty_q;

   // Caller never pushes when full nor pops when empty, so no saturation is needed.
   always_comb begin
      count_d = count_q + CW'(push_i) - CW'(pop_i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

`ifdef WB_FORWARD_EN
   assign mem_o    = mem_q;
   assign rd_ptr_o = rd_ptr_q;
   assign count_o  = count_q;
`endif
endmodule

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - write-back queue: result FIFO, register-file write port and pending scoreboard
// Optional WB_FORWARD_EN adds a combinational lookup of queued/in-flight writes.
module wb_queue #(
   parameter int DEPTH  = wb_pkg::DEFAULT_DEPTH,
   parameter int DATA_W = wb_pkg::DATA_W,
   parameter int ADDR_W = wb_pkg::ADDR_W
) (
   input  logic                 clock_in,
   input  logic                 reset_n,
   input  logic                 issue_valid,
   input  logic [ADDR_W-1:0]    issue_reg,
   wb_queue_if.slave            res,
   output logic [ADDR_W-1:0]    writeReg,
   output logic [DATA_W-1:0]    writeData,
   output logic                 regWrite,
   output logic [2**ADDR_W-1:0] busy_mask,
   output logic                 full,
   output logic                 empty
`ifdef WB_FORWARD_EN
   ,
   input  logic [ADDR_W-1:0]    fwd_reg,
   output logic                 fwd_hit,
   output logic [DATA_W-1:0]    fwd_data
`endif
);
   import wb_pkg::*;

   localparam int NREG = 2**ADDR_W;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] reg_idx;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            head, push_entry;
   logic              accept, push, pop;
   logic [ADDR_W-1:0] write_reg_q;
   logic [DATA_W-1:0] write_data_q;
   logic              reg_write_q;
   logic [NREG-1:0]   busy_q, busy_d;

   assign res.result_ready = ~full;
   assign accept     = res.result_valid & res.result_ready;
   // $zero results are handshaken but never stored.
   assign push       = accept & (res.result_reg != ADDR_W'(REG_ZERO));
   assign pop        = ~empty;
   assign push_entry = '{reg_idx: res.result_reg, data: res.result_data};

`ifdef WB_FORWARD_EN
   logic [$bits(entry_t)-1:0] fifo_mem [DEPTH];
   logic [PW-1:0]             fifo_rd_ptr;
   logic [CW-1:0]             fifo_count;
`endif

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk_i   (clock_in),
      .rst_ni  (reset_n),
      .push_i  (push),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty)
`ifdef WB_FORWARD_EN
      ,
      .mem_o    (fifo_mem),
      .rd_ptr_o (fifo_rd_ptr),
      .count_o  (fifo_count)
`endif
   );

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         write_reg_q  <= '0;
         write_data_q <= '0;
         reg_write_q  <= 1'b0;
      end else if (pop) begin
         write_reg_q  <= head.reg_idx;
         write_data_q <= head.data;
         reg_write_q  <= 1'b1;
      end else begin
         reg_write_q  <= 1'b0;
      end
   end

   // Clear first so a same-cycle issue to the retiring register keeps it busy.
   always_comb begin
      busy_d = busy_q;
      if (pop)         busy_d[head.reg_idx] = 1'b0;
      if (issue_valid) busy_d[issue_reg]    = 1'b1;
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clock_in) begin
      if (!reset_n) busy_q <= '0;
      else          busy_q <= busy_d;
   end

   assign writeReg  = write_reg_q;
   assign writeData = write_data_q;
   assign regWrite  = reg_write_q;
   assign busy_mask = busy_q;

`ifdef WB_FORWARD_EN
   // Walk oldest to newest so the youngest match overwrites earlier ones.
   always_comb begin
      entry_t        e;
      logic [PW-1:0] idx;
      e        = '0;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      if (reg_write_q && (write_reg_q == fwd_reg)) begin
         fwd_hit  = 1'b1;
         fwd_data = write_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = fifo_rd_ptr + PW'(i);
         e   = fifo_mem[idx];
         if ((CW'(i) < fifo_count) && (e.reg_idx == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = e.data;
         end
      end
      if (fwd_reg == ADDR_W'(REG_ZERO)) begin
         fwd_hit  = 1'b0;
         fwd_data = '0;
      end
   end
`endif
endmodule
